ucie_ctl_rx_elastic_buffer: RTL and testbench

UCIE_CTL_RX_ELASTIC_BUFFER -- requirements
Module: ucie_ctl_rx_elastic_buffer

---
 rtl/ucie_ctl_rx_elastic_buffer.sv | 78 +++++++
 tb/tb_ucie_ctl_rx_elastic_buffer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/ucie_ctl_rx_elastic_buffer.sv
// ucie_ctl_rx_elastic_buffer: show-ahead RX elastic FIFO with sticky overflow and saturating drop counter.
// Define UCIE_CTL_RX_PARITY_EN to store a per-entry even-parity bit and flag mismatches on pop.
module ucie_ctl_rx_elastic_buffer #(
  parameter int NBYTES   = 64,
  parameter int DEPTH    = 8,
  parameter int AFULL_TH = DEPTH - 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [8*NBYTES-1:0]       i_rdi_pl_data,
  input  logic                      i_rdi_pl_valid,
  input  logic                      i_buffer_en,
  input  logic                      i_fdi_ready,
  input  logic                      i_clr_overflow,
  output logic [8*NBYTES-1:0]       o_fdi_data,
  output logic                      o_fdi_data_valid,
  output logic [$clog2(DEPTH):0]    o_count,
  output logic                      o_full,
  output logic                      o_empty,
  output logic                      o_almost_full,
  output logic                      o_overflow_detected,
  output logic [15:0]               o_drop_count,
  output logic                      o_parity_err
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_CNT   = (AW+1)'(AFULL_TH);
  logic [8*NBYTES-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic pop, push, drop;
  assign o_count          = count;
  assign o_full           = count == FULL_CNT;
  assign o_empty          = count == '0;
  assign o_almost_full    = count >= AF_CNT;
  assign o_fdi_data_valid = i_buffer_en & ~o_empty;
  assign o_fdi_data       = mem[rd_ptr];
  assign pop              = o_fdi_data_valid & i_fdi_ready;
  assign push             = i_buffer_en & i_rdi_pl_valid & (~o_full | pop);
  assign drop             = i_buffer_en & i_rdi_pl_valid & o_full & ~pop;
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  // A drop coinciding with a clear must still be recorded.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_overflow_detected <= 1'b0;
      o_drop_count        <= '0;
    end else begin
      o_overflow_detected <= drop | (o_overflow_detected & ~i_clr_overflow);
      o_drop_count        <= i_clr_overflow ? {15'd0, drop} :
                             (drop && o_drop_count != 16'hFFFF) ? o_drop_count + 16'd1 : o_drop_count;
    end
  end
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= i_rdi_pl_data;
  end
`ifdef UCIE_CTL_RX_PARITY_EN
  logic par_mem [DEPTH];
  always_ff @(posedge i_clk) begin
    if (push) par_mem[wr_ptr] <= ^i_rdi_pl_data;
  end
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) o_parity_err <= 1'b0;
    else        o_parity_err <= pop & ((^mem[rd_ptr]) != par_mem[rd_ptr]);
  end
`else
  assign o_parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_ucie_ctl_rx_elastic_buffer.sv
// tb_ucie_ctl_rx_elastic_buffer: directed checks of the RX elastic buffer at default parameters.
module tb_ucie_ctl_rx_elastic_buffer;
  localparam int DW = 512;
  logic          i_clk = 0;
  logic          i_rst;
  logic [DW-1:0] i_rdi_pl_data;
  logic          i_rdi_pl_valid, i_buffer_en, i_fdi_ready, i_clr_overflow;
  logic [DW-1:0] o_fdi_data;
  logic          o_fdi_data_valid, o_full, o_empty, o_almost_full;
  logic          o_overflow_detected, o_parity_err;
  logic [3:0]    o_count;
  logic [15:0]   o_drop_count;
  int n_cmp = 0, n_err = 0;

  ucie_ctl_rx_elastic_buffer dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_rdi_pl_data(i_rdi_pl_data),
    .i_rdi_pl_valid(i_rdi_pl_valid), .i_buffer_en(i_buffer_en),
    .i_fdi_ready(i_fdi_ready), .i_clr_overflow(i_clr_overflow),
    .o_fdi_data(o_fdi_data), .o_fdi_data_valid(o_fdi_data_valid),
    .o_count(o_count), .o_full(o_full), .o_empty(o_empty),
    .o_almost_full(o_almost_full), .o_overflow_detected(o_overflow_detected),
    .o_drop_count(o_drop_count), .o_parity_err(o_parity_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    int sent, rx;
    i_rst = 0; i_rdi_pl_data = '0; i_rdi_pl_valid = 0;
    i_buffer_en = 0; i_fdi_ready = 0; i_clr_overflow = 0;
    #3;
    chk("rst_count", o_count, 0);
    chk("rst_empty", o_empty, 1);
    chk("rst_full", o_full, 0);
    chk("rst_afull", o_almost_full, 0);
    chk("rst_valid", o_fdi_data_valid, 0);
    chk("rst_ovf", o_overflow_detected, 0);
    chk("rst_drop", o_drop_count, 0);
    chk("rst_perr", o_parity_err, 0);
    tick;
    i_rst = 1;
    tick;

    // single beat, ready held high
    i_buffer_en = 1; i_fdi_ready = 1; i_rdi_pl_valid = 1;
    i_rdi_pl_data = {64{8'hA5}};
`ifdef UCIE_CTL_RX_PARITY_EN
    tick;
    i_rdi_pl_valid = 0;
    dut.par_mem[0] = ~dut.par_mem[0];
    chk("a5_valid", o_fdi_data_valid, 1);
    tick;
    chk("perr_pulse", o_parity_err, 1);
    tick;
    chk("perr_clear", o_parity_err, 0);
    i_rdi_pl_valid = 1;
`endif
    tick;
    i_rdi_pl_valid = 0;
    chk("a5_valid", o_fdi_data_valid, 1);
    chk("a5_data", o_fdi_data, {64{8'hA5}});
    chk("a5_count1", o_count, 1);
    tick;
    chk("a5_count0", o_count, 0);
    chk("a5_empty", o_empty, 1);
    chk("a5_perr", o_parity_err, 0);

    // overflow: 10 writes into 8 entries with no drain
    i_fdi_ready = 0; i_rdi_pl_valid = 1;
    for (int i = 0; i < 10; i++) begin
      i_rdi_pl_data = DW'(i);
      tick;
      if (i == 4) chk("afull_at5", o_almost_full, 0);
      if (i == 5) chk("afull_at6", o_almost_full, 1);
      if (i == 7) begin
        chk("full_at8", o_full, 1);
        chk("ovf_at8", o_overflow_detected, 0);
      end
    end
    chk("ovf_set", o_overflow_detected, 1);
    chk("drop_2", o_drop_count, 2);
    chk("ovf_count", o_count, 8);
    chk("ovf_head", o_fdi_data, 0);

    // write and pop together while full
    i_rdi_pl_data = DW'(100); i_fdi_ready = 1;
    tick;
    i_rdi_pl_valid = 0;
    chk("wp_count", o_count, 8);
    chk("wp_drop", o_drop_count, 2);
    for (int k = 1; k <= 8; k++) begin
      chk("wp_order", o_fdi_data, DW'(k == 8 ? 100 : k));
      tick;
    end
    chk("wp_empty", o_empty, 1);

    // clear racing a drop, then clear alone
    i_fdi_ready = 0; i_rdi_pl_valid = 1;
    repeat (8) tick;
    i_clr_overflow = 1;
    tick;
    chk("clr_drop_ovf", o_overflow_detected, 1);
    chk("clr_drop_cnt", o_drop_count, 1);
    i_rdi_pl_valid = 0;
    tick;
    i_clr_overflow = 0;
    chk("clr_ovf", o_overflow_detected, 0);
    chk("clr_cnt", o_drop_count, 0);
    i_fdi_ready = 1;
    repeat (8) tick;
    chk("clr_empty", o_empty, 1);

    // disabled buffer ignores traffic and retains contents
    i_fdi_ready = 0; i_rdi_pl_valid = 1; i_rdi_pl_data = DW'(55);
    tick;
    i_buffer_en = 0; i_rdi_pl_data = DW'(66);
    repeat (2) tick;
    chk("dis_valid", o_fdi_data_valid, 0);
    chk("dis_count", o_count, 1);
    chk("dis_drop", o_drop_count, 0);
    i_rdi_pl_valid = 0; i_buffer_en = 1;
    #1;
    chk("dis_resume_v", o_fdi_data_valid, 1);
    chk("dis_resume_d", o_fdi_data, DW'(55));
    i_fdi_ready = 1;
    tick;
    chk("dis_empty", o_empty, 1);

    // incrementing stream with random backpressure across pointer wrap
    sent = 0; rx = 0;
    for (int c = 0; c < 400 && rx < 20; c++) begin
      i_rdi_pl_valid = sent < 20 && !o_full;
      i_rdi_pl_data  = DW'(sent);
      i_fdi_ready    = 1'($urandom_range(0, 1));
      if (o_fdi_data_valid && i_fdi_ready) begin
        chk("wrap_order", o_fdi_data, DW'(rx));
        rx++;
      end
      if (i_rdi_pl_valid) sent++;
      tick;
    end
    i_rdi_pl_valid = 0;
    chk("wrap_total", DW'(rx), DW'(20));

    // asynchronous reset mid-transfer discards queued beats
    i_fdi_ready = 0; i_rdi_pl_valid = 1;
    repeat (3) tick;
    i_rdi_pl_valid = 0;
    #2 i_rst = 0;
    #1;
    chk("arst_count", o_count, 0);
    chk("arst_empty", o_empty, 1);
    chk("arst_valid", o_fdi_data_valid, 0);
    tick;
    i_rst = 1;
    i_rdi_pl_valid = 1; i_rdi_pl_data = DW'(77);
    tick;
    i_rdi_pl_valid = 0;
    chk("arst_new_d", o_fdi_data, DW'(77));
    chk("arst_new_c", o_count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
